// File: rtl/mac_fixed_pipe.sv
// Pipelined signed fixed-point MAC with bias and saturating requantise; ROUND_NEAREST_EN selects round-half-up over floor.
// Latency 4 cycles from the last beat to out_valid; no backpressure, so a beat is accepted on every cycle with in_valid.
module mac_fixed_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_bias,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_q,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              proto_err
);

  localparam int P_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Stage 1: input capture
  logic                     s1_vld, s1_first, s1_last;
  logic signed [DATA_W-1:0] s1_a, s1_b, s1_bias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_bias  <= '0;
    end else begin
      s1_vld   <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_bias  <= in_bias;
    end
  end

  // Stage 2: full-precision product
  logic signed [P_W-1:0]    a_ext, b_ext, prod;
  logic                     s2_vld, s2_first, s2_last;
  logic signed [P_W-1:0]    s2_p;
  logic signed [DATA_W-1:0] s2_bias;

  assign a_ext = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
  assign b_ext = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
      s2_bias  <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_p     <= prod;
      s2_bias  <= s1_bias;
    end
  end

  // Stage 3: accumulate
  logic signed [ACC_W-1:0] acc, acc_nxt, p_ext, bias_ext;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    active, active_nxt;
  logic                    s3_load, load_nxt;
  logic                    s3_err, err_nxt;

  assign p_ext    = {{(ACC_W-P_W){s2_p[P_W-1]}}, s2_p};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){s2_bias[DATA_W-1]}}, s2_bias, {FRAC_W{1'b0}}};

  always_comb begin
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    active_nxt = active;
    load_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (s2_vld) begin
      if (s2_first) begin
        // A first beat always restarts, discarding any open partial sum.
        acc_nxt    = bias_ext + p_ext;
        cnt_nxt    = CNT_ONE;
        active_nxt = !s2_last;
        load_nxt   = s2_last;
      end else if (active) begin
        acc_nxt    = acc + p_ext;
        cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        active_nxt = !s2_last;
        load_nxt   = s2_last;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      active  <= 1'b0;
      s3_load <= 1'b0;
      s3_err  <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      s3_load <= load_nxt;
      s3_err  <= err_nxt;
    end
  end

  // Stage 4: requantise and saturate
  logic signed [ACC_W-1:0] acc_rnd, r;
  logic [DATA_W-1:0]       q_nxt;
  logic                    sat_nxt;

`ifdef ROUND_NEAREST_EN
  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  assign acc_rnd = acc + RND;
`else
  assign acc_rnd = acc;
`endif

  assign r = acc_rnd >>> FRAC_W;

  always_comb begin
    q_nxt   = r[DATA_W-1:0];
    sat_nxt = 1'b0;
    if (r > Q_MAX) begin
      q_nxt   = OUT_MAX;
      sat_nxt = 1'b1;
    end else if (r < Q_MIN) begin
      q_nxt   = OUT_MIN;
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      proto_err <= 1'b0;
      out_q     <= '0;
      out_sat   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      out_valid <= s3_load;
      proto_err <= s3_err;
      if (s3_load) begin
        out_q   <= q_nxt;
        out_sat <= sat_nxt;
        out_cnt <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_mac_fixed_pipe.sv
// Bench for mac_fixed_pipe: constant vector table, hand corner sequences and a cycle-indexed reference scoreboard.
module tb_mac_fixed_pipe;

  localparam int NIDX = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last;
  logic [15:0] in_a, in_b, in_bias;
  logic        out_valid, out_sat, proto_err;
  logic [15:0] out_q;
  logic [9:0]  out_cnt;

  mac_fixed_pipe #(.DATA_W(16), .FRAC_W(15), .ACC_W(40), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
    .out_valid(out_valid), .out_q(out_q), .out_sat(out_sat),
    .out_cnt(out_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int nvld = 0;
  int nerr = 0;

  // Expected outputs, indexed by the rising edge that registers them.
  bit          exp_v [NIDX];
  bit          exp_e [NIDX];
  logic [15:0] exp_q [NIDX];
  bit          exp_s [NIDX];
  logic [9:0]  exp_c [NIDX];

  bit     m_active = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;

  typedef struct {
    logic [15:0] a, b, bias, q;
    logic        sat;
    logic [9:0]  cnt;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic requant(input longint acc, output logic [15:0] q, output logic s);
    longint r;
    r = acc;
`ifdef ROUND_NEAREST_EN
    r = r + 16384;
`endif
    r = r >>> 15;
    s = 1'b1;
    if (r > 32767) q = 16'h7FFF;
    else if (r < -32768) q = 16'h8000;
    else begin
      q = r[15:0];
      s = 1'b0;
    end
  endtask

  // Frame-level reference: value of the sum in real arithmetic, result due 3 edges after capture.
  task automatic model(input int idx, input logic f, input logic l,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias);
    longint p;
    logic [15:0] q;
    logic s;
    p = longint'($signed(a)) * longint'($signed(b));
    if (f) begin
      m_acc = longint'($signed(bias)) * 32768 + p;
      m_cnt = 1;
      m_active = 1'b1;
    end else if (m_active) begin
      m_acc = m_acc + p;
      if (m_cnt < 1023) m_cnt++;
    end else begin
      exp_e[idx+3] = 1'b1;
      return;
    end
    if (l) begin
      requant(m_acc, q, s);
      exp_v[idx+3] = 1'b1;
      exp_q[idx+3] = q;
      exp_s[idx+3] = s;
      exp_c[idx+3] = 10'(m_cnt);
      m_active = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias);
    @(negedge clk);
    in_valid = v;
    in_first = f;
    in_last  = l;
    in_a     = a;
    in_b     = b;
    in_bias  = bias;
    if (v) model(edge_cnt + 1, f, l, a, b, bias);
  endtask

  task automatic beat(input logic f, input logic l,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias);
    drive(1'b1, f, l, a, b, bias);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic chk_held(input string name, input logic [15:0] q, input logic s, input logic [9:0] c);
    chk({name, "_q"}, out_q, q);
    chk({name, "_sat"}, out_sat, s);
    chk({name, "_cnt"}, out_cnt, c);
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (edge_cnt < NIDX) begin
      if (out_valid) nvld++;
      if (proto_err) nerr++;
      chk("sb_valid", out_valid, exp_v[edge_cnt]);
      chk("sb_proto_err", proto_err, exp_e[edge_cnt]);
      if (exp_v[edge_cnt]) begin
        chk("sb_q", out_q, exp_q[edge_cnt]);
        chk("sb_sat", out_sat, exp_s[edge_cnt]);
        chk("sb_cnt", out_cnt, exp_c[edge_cnt]);
      end
    end
  end

  initial begin
    int v0, e0;
    logic v, f, l;

    vt[0] = '{a:16'h4000, b:16'h4000, bias:16'h0000, q:16'h2000, sat:1'b0, cnt:10'd1};
    vt[1] = '{a:16'h4000, b:16'h4000, bias:16'h1000, q:16'h3000, sat:1'b0, cnt:10'd1};
    vt[2] = '{a:16'h8000, b:16'h8000, bias:16'h0000, q:16'h7FFF, sat:1'b1, cnt:10'd1};
    vt[5] = '{a:16'h7FFF, b:16'h7FFF, bias:16'h0000, q:16'h7FFE, sat:1'b0, cnt:10'd1};
    vt[6] = '{a:16'h0000, b:16'h0000, bias:16'h8000, q:16'h8000, sat:1'b0, cnt:10'd1};
`ifdef ROUND_NEAREST_EN
    vt[3] = '{a:16'h0001, b:16'h4000, bias:16'h0000, q:16'h0001, sat:1'b0, cnt:10'd1};
    vt[4] = '{a:16'hFFFF, b:16'h4000, bias:16'h0000, q:16'h0000, sat:1'b0, cnt:10'd1};
`else
    vt[3] = '{a:16'h0001, b:16'h4000, bias:16'h0000, q:16'h0000, sat:1'b0, cnt:10'd1};
    vt[4] = '{a:16'hFFFF, b:16'h4000, bias:16'h0000, q:16'hFFFF, sat:1'b0, cnt:10'd1};
`endif

    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_bias = '0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk_held("rst", 16'h0, 1'b0, 10'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].bias);
      idle(5);
      chk_held($sformatf("vec%0d", i), vt[i].q, vt[i].sat, vt[i].cnt);
    end

    // Three near-1.0 squares overflow the positive range.
    beat(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000);
    beat(1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000);
    beat(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'h0000);
    idle(5);
    chk_held("pos_sat3", 16'h7FFF, 1'b1, 10'd3);

    beat(1'b1, 1'b0, 16'h8000, 16'h7FFF, 16'h0000);
    beat(1'b0, 1'b1, 16'h8000, 16'h7FFF, 16'h0000);
    idle(5);
    chk_held("neg_sat2", 16'h8000, 1'b1, 10'd2);

    // Frame A with bubbles, frame B right after its last, then a stray beat.
    v0 = nvld; e0 = nerr;
    beat(1'b1, 1'b0, 16'h1000, 16'h1000, 16'h0000);
    idle(2);
    beat(1'b0, 1'b1, 16'h2000, 16'h1000, 16'h0000);
    beat(1'b1, 1'b0, 16'h4000, 16'h4000, 16'h0000);
    beat(1'b0, 1'b1, 16'h0800, 16'h4000, 16'h0000);
    beat(1'b0, 1'b1, 16'h7000, 16'h7000, 16'h0000);
    idle(6);
    chk("b2b_pulses", nvld - v0, 2);
    chk("stray_err_pulses", nerr - e0, 1);
    chk_held("b2b_B", 16'h2400, 1'b0, 10'd2);

    // Long frame: term count must stick at its maximum.
    beat(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0100);
    for (int i = 0; i < 1028; i++) beat(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    beat(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    idle(5);
    chk_held("cnt_sat", 16'h0100, 1'b0, 10'd1023);

    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      f = m_active ? (($urandom % 20) == 0) : (($urandom % 10) != 0);
      l = ($urandom % 3) == 0;
      drive(v, f, l, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    idle(6);

    // Reset while a 4-beat frame is inside the pipeline.
    beat(1'b1, 1'b0, 16'h2000, 16'h2000, 16'h0000);
    beat(1'b0, 1'b0, 16'h2000, 16'h2000, 16'h0000);
    beat(1'b0, 1'b0, 16'h2000, 16'h2000, 16'h0000);
    beat(1'b0, 1'b1, 16'h2000, 16'h2000, 16'h0000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    m_active = 1'b0;
    for (int i = edge_cnt; i < edge_cnt + 10; i++) begin
      exp_v[i] = 1'b0;
      exp_e[i] = 1'b0;
    end
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_proto_err", proto_err, 0);
    chk_held("midrst", 16'h0, 1'b0, 10'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("midrst_no_output", out_valid, 0);

    beat(1'b1, 1'b0, 16'h4000, 16'h2000, 16'h0800);
    beat(1'b0, 1'b1, 16'h4000, 16'h2000, 16'h0000);
    idle(5);
    chk_held("post_rst", 16'h2800, 1'b0, 10'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_fixed_pipe.md
Name: mac_fixed_pipe

Overview:
Parametrised, pipelined signed fixed-point multiply-accumulate unit for the LeNet conv/FC datapath. It consumes a stream of operand pairs framed by first/last markers and adds an optional bias on the first beat. It accumulates full-precision products, then requantises the sum to DATA_W with saturation. It is the streaming successor of the combinational 16-bit fixed-point multiplier.

Parameters:
DATA_W, 16, width of operands, bias and result (signed two's complement)
FRAC_W, 15, fractional bits of operands/result (Q(DATA_W-FRAC_W).FRAC_W)
ACC_W, 40, accumulator width; must be >= 2*DATA_W + ceil(log2(max terms)); the accumulator has no overflow check
CNT_W, 10, width of term counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_first  in  1  beat starts a new accumulation
in_last  in  1  beat ends the accumulation
in_a  in  DATA_W  signed operand A
in_b  in  DATA_W  signed operand B
in_bias  in  DATA_W  signed bias, sampled only on first beat
out_valid  out  1  one-cycle result strobe
out_q  out  DATA_W  requantised, saturated result
out_sat  out  1  result was clipped (qualified by out_valid)
out_cnt  out  CNT_W  number of terms in result
proto_err  out  1  one-cycle pulse: beat without in_first while idle

Behaviour:
- Single clock clk. Reset is asynchronous and active-low on rst_n. All flops clear on reset.
- Reset values: out_valid=0, out_q=0, out_sat=0, out_cnt=0, proto_err=0, accumulator=0, active=0. All pipeline valids are 0.
- No backpressure. A beat is accepted on every rising edge with in_valid=1.
- Pipeline: S1 registers a, b, bias, first, last, valid. S2 registers P=a*b (2*DATA_W signed, full precision). S3 updates the accumulator. S4 registers the requantised output.
- Latency: out_valid is high exactly 4 cycles after the edge that sampled in_last (edge T -> out_valid during the cycle after edge T+3).
- Accumulate rules at S3, valid beat only:
  - first=1: acc = sext(bias)<<FRAC_W + sext(P); cnt=1; active=1.
  - first=0 and active=1: acc += sext(P); cnt += 1. cnt saturates at 2^CNT_W-1.
  - first=0 and active=0: beat dropped, acc unchanged, proto_err pulses one cycle at S4 timing.
  - first=1 while active: the previous partial is silently discarded and restarts.
  - last=1 (including first&&last): S4 loads the result with the post-update acc; active=0.
- Invalid beats (bubbles) leave acc/cnt unchanged.
- Requantise: r = acc >>> FRAC_W (arithmetic, floor truncation). If r > 2^(DATA_W-1)-1 then out_q = max and out_sat=1; if r < -2^(DATA_W-1) then out_q = min and out_sat=1; otherwise out_q=r[DATA_W-1:0] and out_sat=0.
- out_q/out_sat/out_cnt hold their last values when out_valid=0.
- Back-to-back frames: in_last at T and in_first at T+1 is legal, producing two results on consecutive-frame timing with no dead cycle.
- Reset mid-frame discards all in-flight beats; no out_valid is produced for them.

Optional Feature:
ROUND_NEAREST_EN
- Defined: before the shift, add 2^(FRAC_W-1) to acc (round half up); saturation is applied after rounding.
- Undefined: pure floor truncation as above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- first&last, a=0x4000, b=0x4000, bias=0 -> 4 cycles later out_valid=1, out_q=0x2000, out_sat=0, out_cnt=1.
- first&last, bias=0x1000, a=0x4000, b=0x4000 -> out_q=0x3000. Then 3-beat frame a=b=0x7FFF each -> out_q=0x7FFF, out_sat=1, out_cnt=3.
- first&last, a=0x8000, b=0x8000 -> out_q=0x7FFF, out_sat=1. Also a=0x8000, b=0x7FFF, a=0x8000, b=0x7FFF (2 beats, sum ~ -2.0) -> out_q=0x8000, out_sat=1.
- a=0x0001, b=0x4000 -> out_q=0x0000 (ROUND_NEAREST_EN: 0x0001). a=0xFFFF, b=0x4000 -> out_q=0xFFFF (ROUND_NEAREST_EN: 0x0000).
- Frame A (2 beats, bubbles between) with last immediately followed by frame B first -> two out_valid pulses, correct independent sums. A beat without in_first after A -> proto_err pulse, B unaffected.
- Assert rst_n low while a 4-beat frame is mid-pipeline -> all outputs 0 immediately, no out_valid. A new frame after release produces the correct result.
